// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan controller for a common-anode N-digit 7-segment display.
// Drives one active-low anode per slot with dead time, leading-zero blanking and frame-aligned commits.
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  shadow_v_q, shadow_v_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]  disp_v_q, disp_v_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic              pending_q, pending_d;
  logic              tick_q, tick_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic              dp_q, dp_d;

  logic              commit;
  logic              dark;
  logic              upper_zero;
  logic [DIGITS-1:0] lz_vec;

  // Next-state: slot counters, shadow/display handoff, and outputs for the upcoming cycle
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    commit      = 1'b0;
    shadow_v_d  = shadow_v_q;
    shadow_dp_d = shadow_dp_q;
    disp_v_d    = disp_v_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;
    lz_vec      = '0;
    upper_zero  = 1'b1;
    anode_d     = '1;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        commit = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Display takes the shadow as it stood before any same-edge load
    if (commit && pending_q) begin
      disp_v_d  = shadow_v_q;
      disp_dp_d = shadow_dp_q;
    end
    if (load) begin
      shadow_v_d  = value_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end

    // lz_vec[i] set when nibbles i..DIGITS-1 are all zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_v_d[4*i +: 4] == 4'h0);
      lz_vec[i]  = upper_zero;
    end

    dark = (cnt_d < BLANK_END) || (lz_blank && (idx_d != '0) && lz_vec[idx_d]);
    if (!dark) begin
      anode_d[idx_d] = 1'b0;
    end
    dp_d     = dark ? 1'b1 : ~disp_dp_d[idx_d];
    nibble_d = disp_v_d[{idx_d, 2'b00} +: 4];
    tick_d   = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_v_q  <= '0;
      shadow_dp_q <= '0;
      disp_v_q    <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      nibble_q    <= 4'h0;
      anode_q     <= '1;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_v_q  <= shadow_v_d;
      shadow_dp_q <= shadow_dp_d;
      disp_v_q    <= disp_v_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      nibble_q    <= nibble_d;
      anode_q     <= anode_d;
      dp_q        <= dp_d;
    end
  end

  assign nibble     = nibble_q;
  assign anode_n    = anode_q;
  assign dp_n       = dp_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule
